// File: rtl/serpent_ks_pkg.sv
// Shared constants and types for the Serpent subkey controller.
// Holds the subkey/key widths, the subkey count per bank, the bank IDs and
// the sequencing FSM state encoding.
package serpent_ks_pkg;

  localparam int NUM_SUBKEYS = 33;
  localparam int SUBKEY_W    = 128;
  localparam int KEY_W       = 256;
  localparam int IDX_W       = 6;

  localparam logic BANK_DATA  = 1'b0;
  localparam logic BANK_TWEAK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_ARM     = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } ks_state_e;

endpackage

// File: rtl/serpent_subkey_ram.sv
// Two-bank subkey store: 2 x NUM_SUBKEYS words of SUBKEY_W bits.
// Ports:
//   i_clk, i_rst      clock, async active-high reset (read register only)
//   i_we/i_waddr/i_wdata  write port, address = {bank, idx}
//   i_re/i_raddr      read request, address = {bank, idx}
//   o_rdata           registered read data, valid the cycle after i_re
// Storage contents are never reset.
module serpent_subkey_ram
  import serpent_ks_pkg::*;
#(
  parameter int NUM_SUBKEYS = serpent_ks_pkg::NUM_SUBKEYS
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_we,
  input  logic [IDX_W:0]      i_waddr,
  input  logic [SUBKEY_W-1:0] i_wdata,
  input  logic                i_re,
  input  logic [IDX_W:0]      i_raddr,
  output logic [SUBKEY_W-1:0] o_rdata
);

  logic [SUBKEY_W-1:0] mem_q [0:1][0:NUM_SUBKEYS-1];
  logic [SUBKEY_W-1:0] rdata_q;

  // Callers only issue in-range indices, so the idx field always lands in the array.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      mem_q[i_waddr[IDX_W]][i_waddr[IDX_W-1:0]] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata_q <= '0;
    end else if (i_re) begin
      rdata_q <= mem_q[i_raddr[IDX_W]][i_raddr[IDX_W-1:0]];
    end
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/serpent_subkey_ctrl.sv
// Serpent key-schedule sequencer and subkey store arbiter for the XTS datapath.
// Accepts key loads for bank 0 (data) or bank 1 (tweak), pulses the key
// schedule, captures its 33 streamed subkeys, and arbitrates the single read
// port between the cipher core (c) and the tweak core (t) with round-robin.
// Ports:
//   i_clk, i_rst                      clock, async active-high reset
//   i_load/i_load_bank/i_key          load request; o_load_ready high in IDLE
//   o_ks_begin/o_ks_key               start pulse and held key to the schedule
//   i_ks_subkey/i_ks_address/i_ks_valid  subkey stream and done level
//   o_bank_valid                      per-bank subkeys complete
//   i_rd_req_x/i_rd_bank_x/i_rd_idx_x read requests (x = c, t)
//   o_rd_gnt_x                        combinational grant
//   o_rd_data/o_rd_dv_x               registered read data and per-requester valid
//   o_error                           sticky key-schedule timeout flag
// Build option: KS_TIMEOUT_EN adds a watchdog on ARM/CAPTURE (limit KS_TIMEOUT);
// without it CAPTURE waits indefinitely and o_error is tied low.
module serpent_subkey_ctrl
  import serpent_ks_pkg::*;
#(
  parameter int NUM_SUBKEYS = serpent_ks_pkg::NUM_SUBKEYS
`ifdef KS_TIMEOUT_EN
  ,
  parameter int KS_TIMEOUT = 255
`endif
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_load,
  input  logic                i_load_bank,
  input  logic [KEY_W-1:0]    i_key,
  output logic                o_load_ready,
  output logic                o_ks_begin,
  output logic [KEY_W-1:0]    o_ks_key,
  input  logic [SUBKEY_W-1:0] i_ks_subkey,
  input  logic [IDX_W-1:0]    i_ks_address,
  input  logic                i_ks_valid,
  output logic [1:0]          o_bank_valid,
  input  logic                i_rd_req_c,
  input  logic                i_rd_req_t,
  input  logic                i_rd_bank_c,
  input  logic                i_rd_bank_t,
  input  logic [IDX_W-1:0]    i_rd_idx_c,
  input  logic [IDX_W-1:0]    i_rd_idx_t,
  output logic                o_rd_gnt_c,
  output logic                o_rd_gnt_t,
  output logic [SUBKEY_W-1:0] o_rd_data,
  output logic                o_rd_dv_c,
  output logic                o_rd_dv_t,
  output logic                o_error
);

  localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(NUM_SUBKEYS);

  ks_state_e         state_q, state_d;
  logic              bank_q, bank_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [1:0]        bank_valid_q, bank_valid_d;
  logic              rr_q, rr_d;
  logic              dv_c_q, dv_t_q;
  logic              ks_we;
  logic              elig_c, elig_t;
  logic              gnt_c, gnt_t;
  logic [IDX_W:0]    rd_addr;

`ifdef KS_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(KS_TIMEOUT - 1);
  logic [7:0] tmo_q, tmo_d;
  logic       err_q, err_d;
`endif

  always_comb begin
    state_d      = state_q;
    bank_d       = bank_q;
    key_d        = key_q;
    bank_valid_d = bank_valid_q;
    o_load_ready = 1'b0;
    o_ks_begin   = 1'b0;
    ks_we        = 1'b0;
`ifdef KS_TIMEOUT_EN
    tmo_d        = tmo_q;
    err_d        = err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        o_load_ready = 1'b1;
        if (i_load) begin
          key_d                     = i_key;
          bank_d                    = i_load_bank;
          bank_valid_d[i_load_bank] = 1'b0;
          state_d                   = ST_START;
        end
      end
      ST_START: begin
        o_ks_begin = 1'b1;
        state_d    = ST_ARM;
`ifdef KS_TIMEOUT_EN
        tmo_d      = '0;
`endif
      end
      // i_ks_valid can still be the level left over from the previous key here.
      ST_ARM: begin
        state_d = ST_CAPTURE;
`ifdef KS_TIMEOUT_EN
        tmo_d   = tmo_q + 8'd1;
`endif
      end
      ST_CAPTURE: begin
        ks_we = (i_ks_address < IDX_LIMIT);
        if (i_ks_valid) begin
          state_d = ST_DONE;
        end
`ifdef KS_TIMEOUT_EN
        tmo_d = tmo_q + 8'd1;
`endif
      end
      ST_DONE: begin
        bank_valid_d[bank_q] = 1'b1;
        state_d              = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
`ifdef KS_TIMEOUT_EN
    // Watchdog abandons the load; the target bank's valid bit stays clear.
    if (((state_q == ST_ARM) || ((state_q == ST_CAPTURE) && !i_ks_valid)) &&
        (tmo_q == TMO_LAST)) begin
      state_d = ST_IDLE;
      err_d   = 1'b1;
    end
`endif
  end

  // A bank being rewritten has its valid bit low, so reads never collide with capture.
  always_comb begin
    elig_c  = i_rd_req_c && bank_valid_q[i_rd_bank_c] && (i_rd_idx_c < IDX_LIMIT);
    elig_t  = i_rd_req_t && bank_valid_q[i_rd_bank_t] && (i_rd_idx_t < IDX_LIMIT);
    gnt_c   = elig_c && (!elig_t || !rr_q);
    gnt_t   = elig_t && (!elig_c || rr_q);
    rr_d    = (elig_c && elig_t) ? ~rr_q : rr_q;
    rd_addr = gnt_t ? {i_rd_bank_t, i_rd_idx_t} : {i_rd_bank_c, i_rd_idx_c};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      bank_q       <= 1'b0;
      key_q        <= '0;
      bank_valid_q <= '0;
      rr_q         <= 1'b0;
      dv_c_q       <= 1'b0;
      dv_t_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      bank_q       <= bank_d;
      key_q        <= key_d;
      bank_valid_q <= bank_valid_d;
      rr_q         <= rr_d;
      dv_c_q       <= gnt_c;
      dv_t_q       <= gnt_t;
    end
  end

`ifdef KS_TIMEOUT_EN
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tmo_q <= '0;
      err_q <= 1'b0;
    end else begin
      tmo_q <= tmo_d;
      err_q <= err_d;
    end
  end
  assign o_error = err_q;
`else
  assign o_error = 1'b0;
`endif

  serpent_subkey_ram #(
    .NUM_SUBKEYS(NUM_SUBKEYS)
  ) u_ram (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_we   (ks_we),
    .i_waddr({bank_q, i_ks_address}),
    .i_wdata(i_ks_subkey),
    .i_re   (gnt_c | gnt_t),
    .i_raddr(rd_addr),
    .o_rdata(o_rd_data)
  );

  assign o_ks_key     = key_q;
  assign o_bank_valid = bank_valid_q;
  assign o_rd_gnt_c   = gnt_c;
  assign o_rd_gnt_t   = gnt_t;
  assign o_rd_dv_c    = dv_c_q;
  assign o_rd_dv_t    = dv_t_q;

endmodule

// File: tb/tb_serpent_subkey_ctrl.sv
// Bench for serpent_subkey_ctrl: a stub key-schedule engine streams a
// deterministic subkey pattern per key; a read driver predicts grants with a
// round-robin model and queues expected read data; a monitor pops and checks
// each o_rd_dv_x beat including its cycle. Define KS_TIMEOUT_EN to add the
// watchdog scenario.
module tb_serpent_subkey_ctrl;
  import serpent_ks_pkg::*;

  logic                clk;
  logic                i_rst;
  logic                i_load;
  logic                i_load_bank;
  logic [KEY_W-1:0]    i_key;
  logic                o_load_ready;
  logic                o_ks_begin;
  logic [KEY_W-1:0]    o_ks_key;
  logic [SUBKEY_W-1:0] i_ks_subkey;
  logic [IDX_W-1:0]    i_ks_address;
  logic                i_ks_valid;
  logic [1:0]          o_bank_valid;
  logic                i_rd_req_c, i_rd_req_t;
  logic                i_rd_bank_c, i_rd_bank_t;
  logic [IDX_W-1:0]    i_rd_idx_c, i_rd_idx_t;
  logic                o_rd_gnt_c, o_rd_gnt_t;
  logic [SUBKEY_W-1:0] o_rd_data;
  logic                o_rd_dv_c, o_rd_dv_t;
  logic                o_error;

  serpent_subkey_ctrl dut (
    .i_clk(clk), .i_rst(i_rst),
    .i_load(i_load), .i_load_bank(i_load_bank), .i_key(i_key),
    .o_load_ready(o_load_ready), .o_ks_begin(o_ks_begin), .o_ks_key(o_ks_key),
    .i_ks_subkey(i_ks_subkey), .i_ks_address(i_ks_address), .i_ks_valid(i_ks_valid),
    .o_bank_valid(o_bank_valid),
    .i_rd_req_c(i_rd_req_c), .i_rd_req_t(i_rd_req_t),
    .i_rd_bank_c(i_rd_bank_c), .i_rd_bank_t(i_rd_bank_t),
    .i_rd_idx_c(i_rd_idx_c), .i_rd_idx_t(i_rd_idx_t),
    .o_rd_gnt_c(o_rd_gnt_c), .o_rd_gnt_t(o_rd_gnt_t),
    .o_rd_data(o_rd_data), .o_rd_dv_c(o_rd_dv_c), .o_rd_dv_t(o_rd_dv_t),
    .o_error(o_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [SUBKEY_W-1:0] d;
    int                  due;
  } sb_item_t;

  sb_item_t            exp_c_q[$];
  sb_item_t            exp_t_q[$];
  logic [SUBKEY_W-1:0] sk_m [2][33];
  logic [1:0]          mdl_bv = 2'b00;
  logic                rr_m   = 1'b0;

  task automatic chk(input string name, input logic [KEY_W-1:0] act, input logic [KEY_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Stub key-schedule output pattern for a given key and subkey index.
  function automatic logic [SUBKEY_W-1:0] skgen(input logic [KEY_W-1:0] k, input int idx);
    logic [31:0] w;
    w = {idx[7:0], 8'h3C, 16'(idx * 40503)};
    return k[255:128] ^ k[127:0] ^ {w, ~w, w ^ 32'h5A5A_0F0F, w + 32'd1};
  endfunction

  // Scoreboard monitor.
  always @(negedge clk) begin
    sb_item_t it;
    if (o_rd_dv_c) begin
      if (exp_c_q.size() == 0) chk("dv_c_unexpected", 1, 0);
      else begin
        it = exp_c_q.pop_front();
        chk("rd_data_c", o_rd_data, it.d);
        chk("dv_c_cycle", cyc, it.due);
      end
    end
    if (o_rd_dv_t) begin
      if (exp_t_q.size() == 0) chk("dv_t_unexpected", 1, 0);
      else begin
        it = exp_t_q.pop_front();
        chk("rd_data_t", o_rd_data, it.d);
        chk("dv_t_cycle", cyc, it.due);
      end
    end
  end

  // Read driver: mode 0 c-only bank0, 1 c bank0 + t bank1, 2 mixed banks, 3 out-of-range indices.
  task automatic read_run(input int n, input int mode);
    logic elc, elt, gc, gt;
    sb_item_t it;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #2;
      case (mode)
        0: begin
          i_rd_req_c = 1; i_rd_bank_c = 0; i_rd_idx_c = (k % 2 == 1) ? 6'd32 : 6'd0;
          i_rd_req_t = 0; i_rd_bank_t = 0; i_rd_idx_t = 0;
        end
        1: begin
          i_rd_req_c = 1; i_rd_bank_c = BANK_DATA;  i_rd_idx_c = 6'(k % 33);
          i_rd_req_t = 1; i_rd_bank_t = BANK_TWEAK; i_rd_idx_t = 6'(32 - (k % 33));
        end
        2: begin
          i_rd_req_c = 1; i_rd_bank_c = 1'(k % 2);       i_rd_idx_c = 6'((k * 5) % 33);
          i_rd_req_t = 1; i_rd_bank_t = 1'((k + 1) % 2); i_rd_idx_t = 6'((k * 11) % 33);
        end
        default: begin
          i_rd_req_c = 1; i_rd_bank_c = 0; i_rd_idx_c = 6'(33 + (k % 31));
          i_rd_req_t = 1; i_rd_bank_t = 1; i_rd_idx_t = (k % 4 == 0) ? 6'd63 : 6'(k % 33);
        end
      endcase
      #1;
      elc = i_rd_req_c && mdl_bv[i_rd_bank_c] && (i_rd_idx_c < 6'd33);
      elt = i_rd_req_t && mdl_bv[i_rd_bank_t] && (i_rd_idx_t < 6'd33);
      gc  = elc && (!elt || !rr_m);
      gt  = elt && (!elc || rr_m);
      if (elc && elt) rr_m = ~rr_m;
      chk("gnt_c", o_rd_gnt_c, gc);
      chk("gnt_t", o_rd_gnt_t, gt);
      if (gc) begin
        it.d = sk_m[i_rd_bank_c][i_rd_idx_c]; it.due = cyc + 1; exp_c_q.push_back(it);
      end
      if (gt) begin
        it.d = sk_m[i_rd_bank_t][i_rd_idx_t]; it.due = cyc + 1; exp_t_q.push_back(it);
      end
    end
    @(posedge clk); #2;
    i_rd_req_c = 0; i_rd_req_t = 0;
  endtask

  // Load a key and play the schedule engine. abort_after >= 0 pulses i_rst at
  // that stream beat; no_stream leaves i_ks_valid low to exercise the watchdog.
  task automatic load_key(input logic bank, input logic [KEY_W-1:0] key,
                          input int abort_after, input bit no_stream);
    @(posedge clk); #1;                       // accept cycle n
    i_load = 1; i_load_bank = bank; i_key = key;
    chk("load_ready_idle", o_load_ready, 1);
    @(posedge clk); #1;                       // n+1: START
    i_load = 0; i_key = ~key;
    mdl_bv[bank] = 0;
    for (int i = 0; i < 33; i++) sk_m[bank][i] = skgen(key, i);
    chk("ks_begin_n1", o_ks_begin, 1);
    chk("ks_key", o_ks_key, key);
    chk("load_ready_busy", o_load_ready, 0);
    chk("bv_cleared", o_bank_valid[bank], 0);
    @(posedge clk); #1;                       // n+2: ARM, stale valid may still be high
    chk("ks_begin_arm", o_ks_begin, 0);
    @(posedge clk); #1;                       // n+3: CAPTURE
    i_ks_valid = 0;
    if (no_stream) begin
      for (int c = 3; c < 256; c++) begin @(posedge clk); #1; end
      chk("tmo_busy_ready", o_load_ready, 0);
      chk("tmo_busy_err", o_error, 0);
      @(posedge clk); #1;                     // ARM + 255
      chk("tmo_ready", o_load_ready, 1);
      chk("tmo_err", o_error, 1);
      chk("tmo_bv", o_bank_valid[bank], 0);
      repeat (3) @(posedge clk); #1;
      chk("tmo_err_sticky", o_error, 1);
      return;
    end
    for (int j = 0; j < 35; j++) begin
      if (j == abort_after) begin
        i_rst = 1; mdl_bv = 2'b00; rr_m = 0;
        @(posedge clk); #1;
        i_rst = 0;
        chk("rst_bv", o_bank_valid, 2'b00);
        chk("rst_ready", o_load_ready, 1);
        chk("rst_begin", o_ks_begin, 0);
        chk("rst_rd_data", o_rd_data, 0);
        return;
      end
      if (j == 0) begin
        i_ks_address = 6'd5;  i_ks_subkey = 128'hDEAD_BEEF_0000_0000_1111_2222_3333_4444;
      end else if (j == 1) begin
        i_ks_address = 6'd40; i_ks_subkey = 128'hBAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0_BAD0;
      end else begin
        i_ks_address = 6'(j - 2); i_ks_subkey = skgen(key, j - 2);
      end
      chk("bv_low_capture", o_bank_valid[bank], 0);
      chk("ks_begin_once", o_ks_begin, 0);
      @(posedge clk); #1;
    end
    i_ks_valid = 1; i_ks_address = 6'd63; i_ks_subkey = '1;
    @(posedge clk); #1;                       // DONE
    chk("bv_low_done", o_bank_valid[bank], 0);
    @(posedge clk); #1;                       // back in IDLE
    chk("bv_set", o_bank_valid[bank], 1);
    chk("ready_after", o_load_ready, 1);
    chk("ks_key_held", o_ks_key, key);
    mdl_bv[bank] = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

  initial begin
    i_rst = 1; i_load = 0; i_load_bank = 0; i_key = '0;
    i_ks_subkey = '0; i_ks_address = '0; i_ks_valid = 0;
    i_rd_req_c = 0; i_rd_req_t = 0; i_rd_bank_c = 0; i_rd_bank_t = 0;
    i_rd_idx_c = 0; i_rd_idx_t = 0;
    @(posedge clk); #1;
    chk("rst_load_ready", o_load_ready, 1);
    chk("rst_bank_valid", o_bank_valid, 0);
    chk("rst_ks_begin", o_ks_begin, 0);
    chk("rst_ks_key", o_ks_key, 0);
    chk("rst_gnt", {o_rd_gnt_c, o_rd_gnt_t}, 0);
    chk("rst_dv", {o_rd_dv_c, o_rd_dv_t}, 0);
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_error", o_error, 0);
    @(posedge clk); #1;
    i_rst = 0;

    load_key(BANK_DATA, '0, -1, 0);
    read_run(4, 0);
    fork
      load_key(BANK_TWEAK, 256'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210_0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0, -1, 0);
      read_run(50, 1);
    join
    read_run(12, 2);
    read_run(10, 3);
    fork
      load_key(BANK_DATA, {8{32'hA5C3_961E}}, -1, 0);
      read_run(45, 0);
    join
    load_key(BANK_DATA, {16{16'h7E81}}, 10, 0);
    load_key(BANK_DATA, {4{64'h1357_9BDF_0246_8ACE}}, -1, 0);
    read_run(6, 0);
`ifdef KS_TIMEOUT_EN
    load_key(BANK_TWEAK, {32{8'h5F}}, -1, 1);
    chk("tmo_other_bank", o_bank_valid[BANK_DATA], 1);
`endif
    repeat (3) @(posedge clk); #1;
    chk("sb_c_drained", exp_c_q.size(), 0);
    chk("sb_t_drained", exp_t_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
